// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the breadboard CPU control path:
// opcodes, control word bit positions and microstep limits.
package cpu_ctrl_pkg;

    localparam int CTRL_W = 16;
    localparam int STEP_W = 3;
    localparam int OPC_W  = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    localparam logic [CTRL_W-1:0] M_HLT = CTRL_W'(1) << B_HLT;
    localparam logic [CTRL_W-1:0] M_MI  = CTRL_W'(1) << B_MI;
    localparam logic [CTRL_W-1:0] M_RI  = CTRL_W'(1) << B_RI;
    localparam logic [CTRL_W-1:0] M_RO  = CTRL_W'(1) << B_RO;
    localparam logic [CTRL_W-1:0] M_IO  = CTRL_W'(1) << B_IO;
    localparam logic [CTRL_W-1:0] M_II  = CTRL_W'(1) << B_II;
    localparam logic [CTRL_W-1:0] M_AI  = CTRL_W'(1) << B_AI;
    localparam logic [CTRL_W-1:0] M_AO  = CTRL_W'(1) << B_AO;
    localparam logic [CTRL_W-1:0] M_EO  = CTRL_W'(1) << B_EO;
    localparam logic [CTRL_W-1:0] M_SU  = CTRL_W'(1) << B_SU;
    localparam logic [CTRL_W-1:0] M_BI  = CTRL_W'(1) << B_BI;
    localparam logic [CTRL_W-1:0] M_OI  = CTRL_W'(1) << B_OI;
    localparam logic [CTRL_W-1:0] M_CE  = CTRL_W'(1) << B_CE;
    localparam logic [CTRL_W-1:0] M_CO  = CTRL_W'(1) << B_CO;
    localparam logic [CTRL_W-1:0] M_J   = CTRL_W'(1) << B_J;
    localparam logic [CTRL_W-1:0] M_FI  = CTRL_W'(1) << B_FI;

    // Final microstep carrying a nonzero word, per opcode class
    localparam logic [STEP_W-1:0] LAST_FETCH = 3'd1;
    localparam logic [STEP_W-1:0] LAST_SHORT = 3'd2;
    localparam logic [STEP_W-1:0] LAST_MEM   = 3'd3;
    localparam logic [STEP_W-1:0] LAST_ALU   = 3'd4;

    function automatic logic [STEP_W-1:0] last_step(
        input logic [OPC_W-1:0] op
    );
        case (op)
            OP_LDA, OP_STA: return LAST_MEM;
            OP_ADD, OP_SUB: return LAST_ALU;
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT: return LAST_SHORT;
            default:        return LAST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Pure combinational microcode table:
// {opcode, step, C, Z} -> 16-bit control word.
module microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_c_flag,
    input  logic              i_z_flag,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic [CTRL_W-1:0] w_word;

    // Fetch words are shared; execute words depend on opcode and step
    always_comb begin
        w_word = '0;
        case (i_step)
            3'd0: w_word = M_CO | M_MI;
            3'd1: w_word = M_RO | M_II | M_CE;
            default: begin
                case (i_opcode)
                    OP_LDA: begin
                        if (i_step == 3'd2) w_word = M_IO | M_MI;
                        else if (i_step == 3'd3) w_word = M_RO | M_AI;
                    end
                    OP_ADD: begin
                        if (i_step == 3'd2) w_word = M_IO | M_MI;
                        else if (i_step == 3'd3) w_word = M_RO | M_BI;
                        else if (i_step == 3'd4) w_word = M_EO | M_AI | M_FI;
                    end
                    OP_SUB: begin
                        if (i_step == 3'd2) w_word = M_IO | M_MI;
                        else if (i_step == 3'd3) w_word = M_RO | M_BI;
                        else if (i_step == 3'd4)
                            w_word = M_EO | M_AI | M_SU | M_FI;
                    end
                    OP_STA: begin
                        if (i_step == 3'd2) w_word = M_IO | M_MI;
                        else if (i_step == 3'd3) w_word = M_AO | M_RI;
                    end
                    OP_LDI: begin
                        if (i_step == 3'd2) w_word = M_IO | M_AI;
                    end
                    OP_JMP: begin
                        if (i_step == 3'd2) w_word = M_IO | M_J;
                    end
                    OP_JC: begin
                        if (i_step == 3'd2 && i_c_flag) w_word = M_IO | M_J;
                    end
                    OP_JZ: begin
                        if (i_step == 3'd2 && i_z_flag) w_word = M_IO | M_J;
                    end
                    OP_OUT: begin
                        if (i_step == 3'd2) w_word = M_AO | M_OI;
                    end
                    OP_HLT: begin
                        if (i_step == 3'd2) w_word = M_HLT;
                    end
                    default: w_word = '0;
                endcase
            end
        endcase
    end

    assign o_ctrl = w_word;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-step counter, RUN/HALT FSM and CTRL gating.
// Optional CTRL_SEQ_EARLY_END_EN: restart fetch after an opcode's last used step.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEPS = 5,
    parameter int OP_W  = 4
) (
    input  logic              CLK,
    input  logic              CLR_n,
    input  logic              RUN,
    input  logic [OP_W-1:0]   OPCODE,
    input  logic              C_FLAG,
    input  logic              Z_FLAG,
    output logic [CTRL_W-1:0] CTRL,
    output logic [STEP_W-1:0] STEP,
    output logic              HALTED
);

    if (STEPS < 5 || STEPS > (1 << STEP_W)) begin : g_bad_steps
        $error("control_sequencer: STEPS must lie in 5..8");
    end

    if (OP_W != OPC_W) begin : g_bad_opw
        $error("control_sequencer: OP_W must be 4");
    end

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    seq_state_t        r_state;
    logic [STEP_W-1:0] r_step;
    logic              r_halted;
    logic [CTRL_W-1:0] w_rom;
    logic              w_active;
    logic              w_wrap;

    microcode_rom u_rom (
        .i_opcode (OPCODE[OPC_W-1:0]),
        .i_step   (r_step),
        .i_c_flag (C_FLAG),
        .i_z_flag (Z_FLAG),
        .o_ctrl   (w_rom)
    );

    assign w_active = (r_state == ST_RUN) && RUN;

`ifdef CTRL_SEQ_EARLY_END_EN
    assign w_wrap = (r_step == STEP_LAST) ||
                    (r_step == last_step(OPCODE[OPC_W-1:0]));
`else
    assign w_wrap = (r_step == STEP_LAST);
`endif

    // Step counter and RUN/HALT state; HALT only exits through CLR_n
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_state  <= ST_RUN;
            r_step   <= '0;
            r_halted <= 1'b0;
        end else if (w_active) begin
            if (w_rom[B_HLT]) begin
                r_state  <= ST_HALT;
                r_halted <= 1'b1;
            end else if (w_wrap) begin
                r_step <= '0;
            end else begin
                r_step <= r_step + STEP_W'(1);
            end
        end
    end

    assign CTRL   = w_active ? w_rom : '0;
    assign STEP   = r_step;
    assign HALTED = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table-driven model
// checked every cycle plus directed literal expectations.
module tb_control_sequencer;

    localparam int NS = 5;

    localparam logic [15:0] K_HLT = 16'h8000;
    localparam logic [15:0] K_MI  = 16'h4000;
    localparam logic [15:0] K_RI  = 16'h2000;
    localparam logic [15:0] K_RO  = 16'h1000;
    localparam logic [15:0] K_IO  = 16'h0800;
    localparam logic [15:0] K_II  = 16'h0400;
    localparam logic [15:0] K_AI  = 16'h0200;
    localparam logic [15:0] K_AO  = 16'h0100;
    localparam logic [15:0] K_EO  = 16'h0080;
    localparam logic [15:0] K_SU  = 16'h0040;
    localparam logic [15:0] K_BI  = 16'h0020;
    localparam logic [15:0] K_OI  = 16'h0010;
    localparam logic [15:0] K_CE  = 16'h0008;
    localparam logic [15:0] K_CO  = 16'h0004;
    localparam logic [15:0] K_J   = 16'h0002;
    localparam logic [15:0] K_FI  = 16'h0001;

    logic        CLK    = 1'b0;
    logic        CLR_n  = 1'b0;
    logic        RUN    = 1'b0;
    logic [3:0]  OPCODE = 4'h0;
    logic        C_FLAG = 1'b0;
    logic        Z_FLAG = 1'b0;
    logic [15:0] CTRL;
    logic [2:0]  STEP;
    logic        HALTED;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] tbl [16][NS];
    int ms = 0;
    bit mh = 1'b0;

    control_sequencer #(.STEPS(NS), .OP_W(4)) dut (
        .CLK    (CLK),
        .CLR_n  (CLR_n),
        .RUN    (RUN),
        .OPCODE (OPCODE),
        .C_FLAG (C_FLAG),
        .Z_FLAG (Z_FLAG),
        .CTRL   (CTRL),
        .STEP   (STEP),
        .HALTED (HALTED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(int op, int s, bit c, bit z);
        logic [15:0] w;
        if (s >= NS) return 16'h0;
        w = tbl[op][s];
        if (op == 7 && s == 2 && !c) w = 16'h0;
        if (op == 8 && s == 2 && !z) w = 16'h0;
        return w;
    endfunction

    function automatic int last_of(int op);
        int l = 1;
        for (int s = 2; s < NS; s++)
            if (tbl[op][s] != 16'h0) l = s;
        return l;
    endfunction

    always @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            ms = 0;
            mh = 1'b0;
        end else if (!mh && RUN) begin
            if ((word_of(int'(OPCODE), ms, C_FLAG, Z_FLAG) & K_HLT) != 0)
                mh = 1'b1;
`ifdef CTRL_SEQ_EARLY_END_EN
            else if (ms == last_of(int'(OPCODE)))
                ms = 0;
`endif
            else
                ms = (ms + 1) % NS;
        end
    end

    always @(negedge CLK) begin
        logic [15:0] e;
        e = (!mh && RUN) ?
            word_of(int'(OPCODE), ms, C_FLAG, Z_FLAG) : 16'h0;
        chk("cyc_ctrl", CTRL, e);
        chk("cyc_step", 16'(STEP), 16'(ms));
        chk("cyc_halted", 16'(HALTED), 16'(mh));
    end

    task automatic adv();
        @(posedge CLK);
        #2;
    endtask

    task automatic back_to_t0(input int from);
        for (int s = from; s < NS; s++) adv();
    endtask

    initial begin
        for (int o = 0; o < 16; o++) begin
            for (int s = 0; s < NS; s++) tbl[o][s] = 16'h0;
            tbl[o][0] = K_CO | K_MI;
            tbl[o][1] = K_RO | K_II | K_CE;
        end
        tbl[1][2]  = K_IO | K_MI;
        tbl[1][3]  = K_RO | K_AI;
        tbl[2][2]  = K_IO | K_MI;
        tbl[2][3]  = K_RO | K_BI;
        tbl[2][4]  = K_EO | K_AI | K_FI;
        tbl[3][2]  = K_IO | K_MI;
        tbl[3][3]  = K_RO | K_BI;
        tbl[3][4]  = K_EO | K_AI | K_SU | K_FI;
        tbl[4][2]  = K_IO | K_MI;
        tbl[4][3]  = K_AO | K_RI;
        tbl[5][2]  = K_IO | K_AI;
        tbl[6][2]  = K_IO | K_J;
        tbl[7][2]  = K_IO | K_J;
        tbl[8][2]  = K_IO | K_J;
        tbl[14][2] = K_AO | K_OI;
        tbl[15][2] = K_HLT;

        // reset state
        #3;
        chk("rst_ctrl_run0", CTRL, 16'h0000);
        chk("rst_step", 16'(STEP), 16'h0);
        chk("rst_halted", 16'(HALTED), 16'h0);
        RUN = 1'b1;
        #1;
        chk("rst_ctrl_run1", CTRL, 16'h4004);
        #8;
        CLR_n = 1'b1;

        // fetch and ADD
        OPCODE = 4'h2;
        adv();
        chk("t1_ctrl", CTRL, 16'h1408);
        chk("t1_step", 16'(STEP), 16'h1);
        adv();
        chk("add_t2", CTRL, 16'h4800);
        adv();
        chk("add_t3", CTRL, 16'h1020);
        adv();
        chk("add_t4", CTRL, 16'h0281);
        adv();
        chk("add_wrap", 16'(STEP), 16'h0);

        // JC taken then flag drops within T2
        OPCODE = 4'h7;
        C_FLAG = 1'b1;
        adv();
        adv();
        chk("jc_taken", CTRL, 16'h0802);
        C_FLAG = 1'b0;
        #1;
        chk("jc_flag_drop", CTRL, 16'h0000);
        adv();
`ifdef CTRL_SEQ_EARLY_END_EN
        chk("jc_end", 16'(STEP), 16'h0);
`else
        chk("jc_end", 16'(STEP), 16'h3);
        back_to_t0(3);
`endif

        // JC not taken
        adv();
        adv();
        chk("jc_not_taken", CTRL, 16'h0000);
        adv();
`ifdef CTRL_SEQ_EARLY_END_EN
        chk("jc_nt_end", 16'(STEP), 16'h0);
`else
        chk("jc_nt_end", 16'(STEP), 16'h3);
        back_to_t0(3);
`endif

        // LDA with RUN frozen at T3
        OPCODE = 4'h1;
        adv();
        adv();
        adv();
        chk("lda_t3", CTRL, 16'h1200);
        RUN = 1'b0;
        #1;
        chk("freeze_ctrl", CTRL, 16'h0000);
        repeat (5) begin
            adv();
            chk("freeze_step", 16'(STEP), 16'h3);
        end
        RUN = 1'b1;
        #1;
        chk("resume_ctrl", CTRL, 16'h1200);
        adv();
`ifdef CTRL_SEQ_EARLY_END_EN
        chk("lda_end", 16'(STEP), 16'h0);
`else
        chk("lda_end", 16'(STEP), 16'h4);
        back_to_t0(4);
`endif

        // async reset mid-ADD at T3
        OPCODE = 4'h2;
        adv();
        adv();
        adv();
        chk("add2_t3", CTRL, 16'h1020);
        #1;
        CLR_n = 1'b0;
        #1;
        chk("mid_rst_step", 16'(STEP), 16'h0);
        chk("mid_rst_ctrl", CTRL, 16'h4004);
        CLR_n = 1'b1;

        // HLT
        OPCODE = 4'hF;
        adv();
        adv();
        chk("hlt_t2", CTRL, 16'h8000);
        chk("hlt_t2_halted", 16'(HALTED), 16'h0);
        adv();
        chk("halt_flag", 16'(HALTED), 16'h1);
        chk("halt_ctrl", CTRL, 16'h0000);
        repeat (20) begin
            adv();
            chk("halt_step", 16'(STEP), 16'h2);
        end
        #1;
        CLR_n = 1'b0;
        #1;
        chk("unhalt_flag", 16'(HALTED), 16'h0);
        chk("unhalt_step", 16'(STEP), 16'h0);
        CLR_n = 1'b1;

        // undefined opcode behaves as NOP
        OPCODE = 4'hA;
        adv();
        chk("nop_t1", CTRL, 16'h1408);
        adv();
`ifdef CTRL_SEQ_EARLY_END_EN
        chk("nop_end", 16'(STEP), 16'h0);
`else
        chk("nop_end", 16'(STEP), 16'h2);
        chk("nop_t2", CTRL, 16'h0000);
`endif
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
